// File: rtl/hpu_pkg.sv
// Shared types and constants for the HPU stream path (get_ctrl / stream_ctrl side).
package hpu_pkg;

  localparam int HPU_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } get_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO. dout always shows the head entry
// when not empty; push into a full FIFO and pop from an empty one are ignored.
module fifo_sync #(
  parameter int W     = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/get_ctrl.sv
// Input-side stage of the HPU stream path: buffers one AXI-Stream packet at a
// time, dispatches it word by word under core_ready, and pulses get_fin when the
// last-tagged word goes out.
module get_ctrl
  import hpu_pkg::*;
#(
  parameter int DW    = HPU_DW,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [DW-1:0]    src_data,
  input  logic             src_last,
  output logic             src_ready,
  input  logic             core_ready,
  output logic             inst_v,
  output logic [DW-1:0]    inst,
  output logic             get_fin,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_CAP = CW'(DEPTH);

  // Saturating increment for the dispatched-word counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  get_state_t       state_q, state_d;
  logic             inst_v_q, inst_v_d;
  logic [DW-1:0]    inst_q, inst_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             accept, fifo_push, fifo_pop, pop_last;
  logic             fifo_empty, fifo_full;
  logic [DW:0]      fifo_dout;
  logic [CW-1:0]    fifo_count;

  // Entries carry the last tag in the MSB so get_fin follows the tag, not a count.
  fifo_sync #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({src_last, src_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Only one packet is ever in flight: intake closes from DRAIN until IDLE.
  assign src_ready = !rst && ((state_q == IDLE) || (state_q == RECV)) &&
                     (fifo_count < FIFO_CAP);
  assign inst_v    = inst_v_q;
  assign inst      = inst_q;
  assign get_fin   = (state_q == FIN);
  assign busy      = (state_q != IDLE);
  assign word_cnt  = word_cnt_q;

  // Next-state, dispatch and counter logic.
  always_comb begin
    accept    = src_valid && src_ready;
    fifo_push = accept && !fifo_full;
    fifo_pop  = core_ready && !fifo_empty;
    pop_last  = fifo_pop && fifo_dout[DW];

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = src_last ? DRAIN : RECV;
      RECV:    if (accept && src_last) state_d = DRAIN;
      DRAIN:   if (pop_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    inst_v_d = fifo_pop;
    inst_d   = fifo_pop ? fifo_dout[DW-1:0] : inst_q;

    word_cnt_d = word_cnt_q;
    if (state_q == FIN) begin
      word_cnt_d = '0;
    end else if (fifo_pop) begin
      word_cnt_d = sat_inc(word_cnt_q);
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inst_v_q   <= 1'b0;
      inst_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inst_v_q   <= inst_v_d;
      inst_q     <= inst_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_get_ctrl.sv
// Bench for get_ctrl: beats are recorded in an expected queue when accepted and
// a negedge monitor pops and compares every dispatched word.
module tb_get_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             src_valid = 1'b0;
  logic [DW-1:0]    src_data = '0;
  logic             src_last = 1'b0;
  logic             core_ready = 1'b0;
  logic             src_ready, inst_v, get_fin, busy;
  logic [DW-1:0]    inst;
  logic [CNT_W-1:0] word_cnt;

  get_ctrl #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_last   (src_last),
    .src_ready  (src_ready),
    .core_ready (core_ready),
    .inst_v     (inst_v),
    .inst       (inst),
    .get_fin    (get_fin),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: packet words in acceptance order with their last tag.
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;
  int exp_wc      = 0;
  int fin_cnt     = 0;
  int last_sent   = 0;
  int run_len     = 0;
  int fin_run_len = 0;
  logic cr_edge   = 1'b0;
  bit   rand_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cr_edge = core_ready;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_wc  = 0;
      run_len = 0;
    end else begin
      if (inst_v) begin
        run_len++;
        exp_wc++;
        check("pop_needs_core_ready", cr_edge, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL inst_unexpected: actual inst_v=1 inst=0x%0h required no word pending", inst);
        end else begin
          mon_e = exp_q.pop_front();
          check("inst_data", inst, mon_e[DW-1:0]);
          check("get_fin_on_last", get_fin, mon_e[DW]);
        end
      end else begin
        check("get_fin_without_word", get_fin, 0);
        run_len = 0;
      end
      check("word_cnt", word_cnt, exp_wc);
      if (get_fin) begin
        fin_cnt++;
        fin_run_len = run_len;
        exp_wc = 0;
      end
    end
  end

  // Offer one beat starting at a negedge; waits at most max_wait extra cycles.
  task automatic send(input logic [DW-1:0] d, input logic l, input int max_wait,
                      output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    src_valid = 1'b1;
    src_data  = d;
    src_last  = l;
    while (!ok && waited <= max_wait) begin
      if (src_ready) begin
        ok = 1'b1;
        exp_q.push_back({l, d});
        if (l) last_sent++;
      end else begin
        waited++;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_chk(input logic [DW-1:0] d, input logic l, input int max_wait);
    bit ok;
    int w;
    send(d, l, max_wait, ok, w);
    check("beat_accepted", ok, 1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    src_valid = 1'b0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_timeout: actual pending=%0d busy=%0b required pending=0 busy=0",
               exp_q.size(), busy);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: actual simulation still running required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fin0, last0, w, seen, total, plen;
    bit ok;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_src_ready", src_ready, 0);
    check("rst_inst_v", inst_v, 0);
    check("rst_inst", inst, 0);
    check("rst_get_fin", get_fin, 0);
    check("rst_busy", busy, 0);
    check("rst_word_cnt", word_cnt, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_src_ready", src_ready, 1);

    // Reset mid-packet
    core_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_chk(32'h100 + i, 1'b0, 4);
    src_valid = 1'b0;
    check("midpkt_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_src_ready", src_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_get_fin", get_fin, 0);
    check("midrst_inst_v", inst_v, 0);
    check("midrst_word_cnt", word_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_after_src_ready", src_ready, 1);
    check("midrst_after_busy", busy, 0);
    core_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen += int'(inst_v) + int'(get_fin);
    end
    check("midrst_fifo_empty", seen, 0);

    // Four-word packet at full rate
    fin0 = fin_cnt;
    send_chk(32'h11, 1'b0, 2);
    send_chk(32'h12, 1'b0, 2);
    send_chk(32'h13, 1'b0, 2);
    send_chk(32'h14, 1'b1, 2);
    wait_idle(50);
    check("p4_fin_count", fin_cnt - fin0, 1);
    check("p4_consecutive", fin_run_len, 4);
    check("p4_word_cnt_cleared", word_cnt, 0);

    // FIFO fill with core_ready low
    core_ready = 1'b0;
    fin0 = fin_cnt;
    for (int i = 0; i < 16; i++) send_chk(32'h200 + i, 1'b0, 2);
    send(32'h210, 1'b0, 8, ok, w);
    check("full_stalls_beat17", ok, 0);
    check("full_src_ready", src_ready, 0);
    core_ready = 1'b1;
    for (int i = 16; i < 20; i++) send_chk(32'h200 + i, (i == 19), 40);
    wait_idle(100);
    check("full_fin_count", fin_cnt - fin0, 1);

    // Single-beat packet
    fin0 = fin_cnt;
    send_chk(32'hABCD, 1'b1, 2);
    wait_idle(20);
    check("single_fin_count", fin_cnt - fin0, 1);
    check("single_run_len", fin_run_len, 1);
    check("single_idle", busy, 0);

    // Back-to-back packets
    fin0 = fin_cnt;
    send_chk(32'h301, 1'b0, 2);
    send_chk(32'h302, 1'b0, 2);
    send_chk(32'h303, 1'b1, 2);
    check("b2b_drain_ready", src_ready, 0);
    send(32'h401, 1'b0, 20, ok, w);
    check("b2b_accepted", ok, 1);
    check("b2b_stalled", (w >= 2), 1);
    send_chk(32'h402, 1'b0, 4);
    send_chk(32'h403, 1'b1, 4);
    wait_idle(50);
    check("b2b_fin_count", fin_cnt - fin0, 2);

    // Randomized traffic
    fin0  = fin_cnt;
    last0 = last_sent;
    total = 0;
    fork
      begin
        while (total < 1000) begin
          plen = $urandom_range(1, 8);
          if (total + plen > 1000) plen = 1000 - total;
          for (int k = 0; k < plen; k++) begin
            send_chk($urandom, (k == plen - 1), 400);
            total++;
            if ($urandom_range(0, 3) == 0) begin
              src_valid = 1'b0;
              repeat ($urandom_range(1, 3)) @(negedge clk);
            end
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          #2 core_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    core_ready = 1'b1;
    wait_idle(2000);
    check("rand_fin_vs_last", fin_cnt - fin0, last_sent - last0);
    check("rand_all_dispatched", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
